crc_stream_engine: RTL and testbench

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

---
 rtl/crc_pkg.sv | 63 ++++++
 rtl/crc_byte_step.sv | 36 +++
 rtl/crc_stream_engine.sv | 156 +++++++++++++++
 tb/tb_crc_stream_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC presets, FSM state type and keep/reflection helpers for the CRC stream engine.
package crc_pkg;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xorout;
    logic        refin;
    logic        refout;
    logic [31:0] residue;
  } crc_preset_t;

  localparam crc_preset_t CRC32_ETH = '{
    poly:    32'h04C11DB7,
    init:    32'hFFFFFFFF,
    xorout:  32'hFFFFFFFF,
    refin:   1'b1,
    refout:  1'b1,
    residue: 32'hDEBB20E3
  };

  localparam crc_preset_t CRC16_CCITT_FALSE = '{
    poly:    32'h00001021,
    init:    32'h0000FFFF,
    xorout:  32'h00000000,
    refin:   1'b0,
    refout:  1'b0,
    residue: 32'h00000000
  };

  localparam crc_preset_t CRC8 = '{
    poly:    32'h00000007,
    init:    32'h00000000,
    xorout:  32'h00000000,
    refin:   1'b0,
    refout:  1'b0,
    residue: 32'h00000000
  };

  localparam int MAX_BYTES = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } crc_state_e;

  // A keep mask is contiguous from lane 0 when it has the form 2^k-1.
  function automatic logic keep_contiguous(input logic [MAX_BYTES-1:0] keep);
    return (keep & (keep + 8'd1)) == '0;
  endfunction

  function automatic logic [31:0] reflect_bits(input logic [31:0] value, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        r = r | (((value >> (width - 1 - i)) & 32'd1) << i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational single-byte CRC update; the reflected form shifts LSB-first with the mirrored polynomial.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter bit          REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       byte_in,
  output logic [CRC_W-1:0] crc_out
);

  localparam logic [CRC_W-1:0] POLY_N   = POLY[CRC_W-1:0];
  localparam logic [31:0]      POLY_R32 = reflect_bits(POLY, CRC_W);
  localparam logic [CRC_W-1:0] POLY_R   = POLY_R32[CRC_W-1:0];

  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc_in;
    if (REFIN) begin
      c[7:0] = c[7:0] ^ byte_in;
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
      end
    end else begin
      c[CRC_W-1 -: 8] = c[CRC_W-1 -: 8] ^ byte_in;
      for (int b = 0; b < 8; b++) begin
        c = c[CRC_W-1] ? ((c << 1) ^ POLY_N) : (c << 1);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: folds all kept bytes of a beat per cycle and holds one framed result
// (CRC, residue match, length, keep error) in a single-entry output buffer.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter int          CRC_W      = 32,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
  parameter bit          REFIN      = 1'b1,
  parameter bit          REFOUT     = 1'b1,
  parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  input  logic                    in_last,
  input  logic                    check_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CRC_W-1:0]        out_crc,
  output logic                    out_match,
  output logic [15:0]             out_len,
  output logic                    out_err
);

  localparam logic [CRC_W-1:0]      INIT_V    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0]      XOROUT_V  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0]      RESIDUE_V = RESIDUE[CRC_W-1:0];
  localparam logic [DATA_BYTES-1:0] KEEP_ALL  = '1;

  crc_state_e       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [15:0]      len_q;
  logic             err_q;
  logic             chk_q;

  logic             out_valid_q;
  logic [CRC_W-1:0] out_crc_q;
  logic             out_match_q;
  logic [15:0]      out_len_q;
  logic             out_err_q;

  logic             beat_fire;
  logic [CRC_W-1:0] chain [DATA_BYTES+1];
  logic [CRC_W-1:0] step_out [DATA_BYTES];
  logic [CRC_W-1:0] crc_d;
  logic [CRC_W-1:0] crc_rev;
  logic [CRC_W-1:0] crc_pre_xor;
  logic [3:0]       kept_cnt;
  logic [16:0]      len_sum;
  logic [15:0]      len_d;
  logic             keep_bad;
  logic             err_d;
  logic             chk_d;
  logic             match_d;

  // Ready depends only on the result buffer, never on in_valid.
  assign in_ready  = !out_valid_q || out_ready;
  assign beat_fire = in_valid && in_ready;

  // crc_q already holds INIT whenever no frame is open, so the chain always starts from it.
  assign chain[0] = crc_q;

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      crc_byte_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .REFIN (REFIN)
      ) u_step (
        .crc_in  (chain[gi]),
        .byte_in (in_data[8*gi +: 8]),
        .crc_out (step_out[gi])
      );
      assign chain[gi+1] = in_keep[gi] ? step_out[gi] : chain[gi];
    end
  endgenerate

  assign crc_d = chain[DATA_BYTES];

  always_comb begin
    kept_cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      kept_cnt = kept_cnt + {3'b000, in_keep[i]};
    end
  end

  assign len_sum = {1'b0, len_q} + {13'd0, kept_cnt};
  assign len_d   = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  assign keep_bad = !keep_contiguous(MAX_BYTES'(in_keep)) || (!in_last && (in_keep != KEEP_ALL));
  assign err_d    = err_q || keep_bad;
  assign chk_d    = (state_q == ST_IDLE) ? check_en : chk_q;

  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < CRC_W; i++) begin
      crc_rev[i] = crc_d[CRC_W-1-i];
    end
  end

  // The register is kept in input bit order; flip it only when the output order differs.
  assign crc_pre_xor = (REFIN != REFOUT) ? crc_rev : crc_d;
  assign match_d     = chk_d && (crc_pre_xor == RESIDUE_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT_V;
      len_q       <= '0;
      err_q       <= 1'b0;
      chk_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_crc_q   <= '0;
      out_match_q <= 1'b0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (beat_fire) begin
        if (in_last) begin
          state_q     <= ST_IDLE;
          crc_q       <= INIT_V;
          len_q       <= '0;
          err_q       <= 1'b0;
          chk_q       <= 1'b0;
          out_valid_q <= 1'b1;
          out_crc_q   <= crc_pre_xor ^ XOROUT_V;
          out_match_q <= match_d;
          out_len_q   <= len_d;
          out_err_q   <= err_d;
        end else begin
          state_q <= ST_BUSY;
          crc_q   <= crc_d;
          len_q   <= len_d;
          err_q   <= err_d;
          chk_q   <= chk_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;
  assign out_match = out_match_q;
  assign out_len   = out_len_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomised scoreboard bench for crc_stream_engine plus directed checks on 1-byte and CRC-16 builds.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] crc;
    logic        match;
    logic [15:0] len;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance: defaults, 4 lanes
  logic        rst, in_valid, in_ready, in_last, check_en, out_valid, out_ready, out_match, out_err;
  logic [31:0] in_data, out_crc;
  logic [3:0]  in_keep;
  logic [15:0] out_len;

  // aux A: 1 lane, defaults
  logic        a_rst, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_match, a_out_err;
  logic [7:0]  a_in_data;
  logic [0:0]  a_in_keep;
  logic [31:0] a_out_crc;
  logic [15:0] a_out_len;

  // aux B: 2 lanes, CRC-16/CCITT-FALSE
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_match, b_out_err;
  logic [15:0] b_in_data, b_out_crc, b_out_len;
  logic [1:0]  b_in_keep;

  crc_stream_engine u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .check_en(check_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_crc(out_crc), .out_match(out_match), .out_len(out_len),
    .out_err(out_err)
  );

  crc_stream_engine #(.DATA_BYTES(1)) u_d1 (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_keep(a_in_keep), .in_last(a_in_last), .check_en(1'b0), .out_valid(a_out_valid),
    .out_ready(1'b1), .out_crc(a_out_crc), .out_match(a_out_match), .out_len(a_out_len),
    .out_err(a_out_err)
  );

  crc_stream_engine #(
    .DATA_BYTES(2), .CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOROUT(32'h0),
    .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(32'h0)
  ) u_c16 (
    .clk(clk), .rst(a_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_keep(b_in_keep), .in_last(b_in_last), .check_en(1'b0), .out_valid(b_out_valid),
    .out_ready(1'b1), .out_crc(b_out_crc), .out_match(b_out_match), .out_len(b_out_len),
    .out_err(b_out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refl(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r = r | (((v >> (w - 1 - i)) & 32'd1) << i);
    return r;
  endfunction

  // Textbook MSB-first CRC over a byte list; reflection applied to data and result as the model defines.
  function automatic logic [31:0] crc_ref(input bq_t q, input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xorout,
                                          input bit refin, input bit refout);
    logic [31:0] mask, top, c, d;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    top  = 32'h1 << (w - 1);
    c    = init & mask;
    foreach (q[k]) begin
      d = refin ? refl({24'h0, q[k]}, 8) : {24'h0, q[k]};
      c = c ^ (d << (w - 8));
      for (int b = 0; b < 8; b++) c = ((c & top) != 0) ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
    end
    if (refout) c = refl(c, w);
    return (c ^ xorout) & mask;
  endfunction

  function automatic logic [31:0] crc32(input bq_t q);
    return crc_ref(q, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
  endfunction

  function automatic bit keep_legal(input logic [3:0] k, input logic last);
    bit seen_zero;
    if (!last) return k == 4'hF;
    seen_zero = 0;
    for (int l = 0; l < 4; l++) begin
      if (!k[l]) seen_zero = 1;
      else if (seen_zero) return 0;
    end
    return 1;
  endfunction

  // ---------------- scoreboard for the main instance ----------------
  exp_t exp_q[$];
  bq_t  cur_bytes;
  logic cur_err, cur_chk;
  bit   cur_open = 0;
  int   rdy_mode = 0;

  initial begin
    exp_t        e;
    logic [31:0] f;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        cur_bytes.delete();
        cur_open = 0;
      end else begin
        chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_result: out_valid=1 crc %h with no result expected", out_crc);
          end else begin
            e = exp_q[0];
            chk("out_crc", out_crc, e.crc);
            chk("out_match", {31'd0, out_match}, {31'd0, e.match});
            chk("out_len", {16'd0, out_len}, {16'd0, e.len});
            chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          if (!cur_open) begin
            cur_open = 1;
            cur_chk  = check_en;
            cur_err  = 0;
            cur_bytes.delete();
          end
          for (int l = 0; l < 4; l++) if (in_keep[l]) cur_bytes.push_back(in_data[8*l +: 8]);
          if (!keep_legal(in_keep, in_last)) cur_err = 1;
          if (in_last) begin
            f       = crc32(cur_bytes);
            e.crc   = f;
            e.match = cur_chk && ((f ^ 32'hFFFFFFFF) == 32'hDEBB20E3);
            e.len   = (cur_bytes.size() > 65535) ? 16'hFFFF : 16'(cur_bytes.size());
            e.err   = cur_err;
            exp_q.push_back(e);
            cur_open = 0;
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic c);
    int n;
    bit ok;
    n = 0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l; check_en = c;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_keep = 4'h0;
  endtask

  task automatic send_msg(input logic c);
    send_beat(32'h34333231, 4'hF, 1'b0, c);
    send_beat(32'h38373635, 4'hF, 1'b0, c);
    send_beat(32'h00000039, 4'h1, 1'b1, c);
  endtask

  bit aux_done = 0;

  initial begin
    bq_t msg, fcs;
    logic [3:0] k;
    logic       l;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; check_en = 1'b0;

    chk("model_crc32", crc32(msg), 32'hCBF43926);
    chk("model_crc16", crc_ref(msg, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0), 32'h29B1);
    chk("model_residue", crc32(fcs) ^ 32'hFFFFFFFF, 32'hDEBB20E3);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_crc", out_crc, 32'd0);
    chk("reset_out_match", {31'd0, out_match}, 32'd0);
    chk("reset_out_len", {16'd0, out_len}, 32'd0);
    chk("reset_out_err", {31'd0, out_err}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // three-beat "123456789"
    send_msg(1'b0);
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("msg_crc", out_crc, 32'hCBF43926);
    chk("msg_len", {16'd0, out_len}, 32'd9);
    @(posedge clk); #1;

    // residue check, then with one flipped bit, then with check_en low
    rdy_mode = 2;
    @(posedge clk); #1;
    send_beat(32'h34333231, 4'hF, 1'b0, 1'b1);
    send_beat(32'h38373635, 4'hF, 1'b0, 1'b0);
    send_beat(32'hF4392639, 4'hF, 1'b0, 1'b0);
    send_beat(32'h000000CB, 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    chk("residue_match", {31'd0, out_match}, 32'd1);
    @(posedge clk); #1;
    send_beat(32'h34333230, 4'hF, 1'b0, 1'b1);
    send_beat(32'h38373635, 4'hF, 1'b0, 1'b1);
    send_beat(32'hF4392639, 4'hF, 1'b0, 1'b1);
    send_beat(32'h000000CB, 4'h1, 1'b1, 1'b1);
    @(negedge clk);
    chk("residue_flip_match", {31'd0, out_match}, 32'd0);
    @(posedge clk); #1;
    send_beat(32'h34333231, 4'hF, 1'b0, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0, 1'b1);
    send_beat(32'hF4392639, 4'hF, 1'b0, 1'b1);
    send_beat(32'h000000CB, 4'h1, 1'b1, 1'b1);
    @(negedge clk);
    chk("check_off_match", {31'd0, out_match}, 32'd0);
    @(posedge clk); #1;

    // empty last beat
    send_beat(32'hA5A5A5A5, 4'hF, 1'b0, 1'b0);
    send_beat(32'hFFFFFFFF, 4'h0, 1'b1, 1'b0);

    // result held for five cycles, then two frames back to back
    rdy_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(32'h11223344, 4'h7, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    rdy_mode = 2;
    send_beat(32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    send_beat(32'h0BADF00D, 4'h3, 1'b1, 1'b0);

    // reset in the middle of a frame
    send_beat(32'h01020304, 4'hF, 1'b0, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_msg(1'b0);
    @(negedge clk);
    chk("after_reset_crc", out_crc, 32'hCBF43926);
    @(posedge clk); #1;
    send_beat(32'h99887766, 4'h5, 1'b1, 1'b0);
    @(negedge clk);
    chk("noncontig_err", {31'd0, out_err}, 32'd1);
    @(posedge clk); #1;

    // random beats with random backpressure and gaps
    rdy_mode = 0;
    for (int n = 0; n < 500; n++) begin
      l = ($urandom_range(0, 3) == 0);
      k = l ? 4'((32'h1 << $urandom_range(0, 4)) - 1) : 4'hF;
      if ($urandom_range(0, 7) == 0) k = 4'($urandom);
      send_beat($urandom, k, l, 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    send_beat($urandom, 4'h3, 1'b1, 1'b0);

    rdy_mode = 2;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", exp_q.size(), 32'd0);

    for (int n = 0; n < 500 && !aux_done; n++) @(posedge clk);
    chk("aux_finished", {31'd0, aux_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- directed checks on the 1-lane and CRC-16 builds ----------------
  initial begin
    int n;
    logic [15:0] words [5];
    words = '{16'h3231, 16'h3433, 16'h3635, 16'h3837, 16'h0039};
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_keep = '0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_keep = '0; b_in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 a_rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(8'h31 + i); a_in_keep = 1'b1; a_in_last = (i == 8);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    chk("d1_valid", {31'd0, a_out_valid}, 32'd1);
    chk("d1_crc", a_out_crc, 32'hCBF43926);
    chk("d1_len", {16'd0, a_out_len}, 32'd9);
    chk("d1_err", {31'd0, a_out_err}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_in_data = words[i]; b_in_keep = (i == 4) ? 2'b01 : 2'b11; b_in_last = (i == 4);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    n = 0;
    while (!b_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    chk("c16_valid", {31'd0, b_out_valid}, 32'd1);
    chk("c16_crc", {16'd0, b_out_crc}, 32'h29B1);
    chk("c16_len", {16'd0, b_out_len}, 32'd9);
    chk("c16_err", {31'd0, b_out_err}, 32'd0);
    aux_done = 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
